// File: rtl/br_resolve.sv
// rtl/br_resolve.sv - branch resolution queue: in-order alloc, out-of-order resolve, rollback, in-order retire
//
// Ports:
//   clock_i, reset_i           single clock; synchronous active-low reset
//   alloc_valid_i/pc/pred_*    per-slot branch allocation (slot 0 oldest)
//   alloc_ready_o, alloc_tag_o combinational accept flag and compacted tags
//   res_valid_i/tag/taken/target  one out-of-order outcome per cycle
//   rollback_en/target/tag_o   registered one-cycle redirect on mispredict
//   upd_is_branch/taken/npc/target_o  registered in-order retire packet for BHT/BTB training
module br_resolve #(
    parameter int NUM_SUPER = 2,
    parameter int BRQ_DEPTH = 8,
    parameter int TAG_W     = 3
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic [NUM_SUPER-1:0]            alloc_valid_i,
    input  logic [NUM_SUPER-1:0][63:0]      alloc_pc_i,
    input  logic [NUM_SUPER-1:0]            alloc_pred_taken_i,
    input  logic [NUM_SUPER-1:0][63:0]      alloc_pred_target_i,
    output logic                            alloc_ready_o,
    output logic [NUM_SUPER-1:0][TAG_W-1:0] alloc_tag_o,
    input  logic                            res_valid_i,
    input  logic [TAG_W-1:0]                res_tag_i,
    input  logic                            res_taken_i,
    input  logic [63:0]                     res_target_i,
    output logic                            rollback_en_o,
    output logic [63:0]                     rollback_target_o,
    output logic [TAG_W-1:0]                rollback_tag_o,
    output logic [NUM_SUPER-1:0]            upd_is_branch_o,
    output logic [NUM_SUPER-1:0]            upd_taken_o,
    output logic [NUM_SUPER-1:0][63:0]      upd_npc_o,
    output logic [NUM_SUPER-1:0][63:0]      upd_target_o
);

    localparam int PW = TAG_W + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(BRQ_DEPTH);
    localparam logic [PW-1:0] SUPER_P = PW'(NUM_SUPER);

    // entry state
    logic [BRQ_DEPTH-1:0] valid_q, valid_d;
    logic [BRQ_DEPTH-1:0] resolved_q, resolved_d;
    logic [BRQ_DEPTH-1:0] pred_taken_q, pred_taken_d;
    logic [BRQ_DEPTH-1:0] act_taken_q, act_taken_d;
    logic [63:0]          pc_q [BRQ_DEPTH];
    logic [63:0]          pc_d [BRQ_DEPTH];
    logic [63:0]          pred_target_q [BRQ_DEPTH];
    logic [63:0]          pred_target_d [BRQ_DEPTH];
    logic [63:0]          act_target_q [BRQ_DEPTH];
    logic [63:0]          act_target_d [BRQ_DEPTH];

    // pointers carry a wrap bit so that full (count==DEPTH) is distinguishable from empty
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [PW-1:0]        count_q, count_d;
    logic [TAG_W-1:0]     head_idx, tail_idx;

    // registered outputs
    logic                            rollback_en_q, rollback_en_d;
    logic [63:0]                     rollback_target_q, rollback_target_d;
    logic [TAG_W-1:0]                rollback_tag_q, rollback_tag_d;
    logic [NUM_SUPER-1:0]            upd_is_branch_q, upd_is_branch_d;
    logic [NUM_SUPER-1:0]            upd_taken_q, upd_taken_d;
    logic [NUM_SUPER-1:0][63:0]      upd_npc_q, upd_npc_d;
    logic [NUM_SUPER-1:0][63:0]      upd_target_q, upd_target_d;

    // combinational helpers
    logic [PW-1:0]                   alloc_cnt;
    logic                            alloc_fire;
    logic                            res_ok;
    logic                            mispredict;
    logic [TAG_W-1:0]                res_age;
    logic [TAG_W-1:0]                age_j;
    logic [NUM_SUPER-1:0][TAG_W-1:0] ret_idx;
    logic [NUM_SUPER-1:0]            ret_mask;
    logic [PW-1:0]                   ret_cnt;
    logic                            run_ok;

    assign head_idx      = head_q[TAG_W-1:0];
    assign tail_idx      = tail_q[TAG_W-1:0];
    assign alloc_ready_o = (DEPTH_P - count_q) >= SUPER_P;

    // Valid slots get consecutive tags from tail, compacted; an idle slot reports
    // tail+slot so the tag pair is stable ({1,0} from an empty queue).
    always_comb begin
        alloc_cnt   = '0;
        alloc_tag_o = '0;
        for (int i = 0; i < NUM_SUPER; i++) begin
            if (alloc_valid_i[i]) begin
                alloc_tag_o[i] = tail_idx + alloc_cnt[TAG_W-1:0];
                alloc_cnt      = alloc_cnt + PW'(1);
            end else begin
                alloc_tag_o[i] = tail_idx + TAG_W'(i);
            end
        end
    end

    // Longest run of valid+resolved entries from head, capped at NUM_SUPER.
    always_comb begin
        run_ok   = 1'b1;
        ret_cnt  = '0;
        ret_mask = '0;
        ret_idx  = '0;
        for (int k = 0; k < NUM_SUPER; k++) begin
            ret_idx[k] = head_idx + TAG_W'(k);
            if (run_ok && valid_q[ret_idx[k]] && resolved_q[ret_idx[k]]) begin
                ret_mask[k] = 1'b1;
                ret_cnt     = ret_cnt + PW'(1);
            end else begin
                run_ok = 1'b0;
            end
        end
    end

    assign res_ok     = res_valid_i && valid_q[res_tag_i] && !resolved_q[res_tag_i];
    assign mispredict = res_ok &&
                        ((res_taken_i != pred_taken_q[res_tag_i]) ||
                         (res_taken_i && (res_target_i != pred_target_q[res_tag_i])));
    // position of the resolved entry relative to head; everything further is younger
    assign res_age    = res_tag_i - head_idx;
    assign alloc_fire = alloc_ready_o && !mispredict && (|alloc_valid_i);

    always_comb begin
        valid_d           = valid_q;
        resolved_d        = resolved_q;
        pred_taken_d      = pred_taken_q;
        act_taken_d       = act_taken_q;
        pc_d              = pc_q;
        pred_target_d     = pred_target_q;
        act_target_d      = act_target_q;
        head_d            = head_q;
        tail_d            = tail_q;
        age_j             = '0;
        rollback_en_d     = 1'b0;
        rollback_target_d = '0;
        rollback_tag_d    = '0;
        upd_is_branch_d   = '0;
        upd_taken_d       = '0;
        upd_npc_d         = '0;
        upd_target_d      = '0;

        // resolution; retirement below only touches entries already resolved,
        // so it never collides with res_tag_i
        if (res_ok) begin
            resolved_d[res_tag_i]   = 1'b1;
            act_taken_d[res_tag_i]  = res_taken_i;
            act_target_d[res_tag_i] = res_target_i;
        end

        for (int k = 0; k < NUM_SUPER; k++) begin
            if (ret_mask[k]) begin
                valid_d[ret_idx[k]]    = 1'b0;
                resolved_d[ret_idx[k]] = 1'b0;
                upd_is_branch_d[k]     = 1'b1;
                upd_taken_d[k]         = act_taken_q[ret_idx[k]];
                upd_npc_d[k]           = pc_q[ret_idx[k]];
                upd_target_d[k]        = act_taken_q[ret_idx[k]] ? act_target_q[ret_idx[k]]
                                                                 : pc_q[ret_idx[k]] + 64'd4;
            end
        end
        head_d = head_q + ret_cnt;

        if (mispredict) begin
            rollback_en_d     = 1'b1;
            rollback_target_d = res_taken_i ? res_target_i : pc_q[res_tag_i] + 64'd4;
            rollback_tag_d    = res_tag_i;
            for (int j = 0; j < BRQ_DEPTH; j++) begin
                age_j = TAG_W'(j) - head_idx;
                if (valid_q[j] && (age_j > res_age)) begin
                    valid_d[j]    = 1'b0;
                    resolved_d[j] = 1'b0;
                end
            end
            tail_d = head_q + PW'(res_age) + PW'(1);
        end else if (alloc_fire) begin
            for (int i = 0; i < NUM_SUPER; i++) begin
                if (alloc_valid_i[i]) begin
                    valid_d[alloc_tag_o[i]]       = 1'b1;
                    resolved_d[alloc_tag_o[i]]    = 1'b0;
                    pc_d[alloc_tag_o[i]]          = alloc_pc_i[i];
                    pred_taken_d[alloc_tag_o[i]]  = alloc_pred_taken_i[i];
                    pred_target_d[alloc_tag_o[i]] = alloc_pred_target_i[i];
                end
            end
            tail_d = tail_q + alloc_cnt;
        end

        count_d = tail_d - head_d;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            valid_q           <= '0;
            resolved_q        <= '0;
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            rollback_en_q     <= 1'b0;
            rollback_target_q <= '0;
            rollback_tag_q    <= '0;
            upd_is_branch_q   <= '0;
            upd_taken_q       <= '0;
            upd_npc_q         <= '0;
            upd_target_q      <= '0;
        end else begin
            valid_q           <= valid_d;
            resolved_q        <= resolved_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            rollback_en_q     <= rollback_en_d;
            rollback_target_q <= rollback_target_d;
            rollback_tag_q    <= rollback_tag_d;
            upd_is_branch_q   <= upd_is_branch_d;
            upd_taken_q       <= upd_taken_d;
            upd_npc_q         <= upd_npc_d;
            upd_target_q      <= upd_target_d;
        end
    end

    // payload storage needs no reset: it is only observed behind valid/resolved
    always_ff @(posedge clock_i) begin
        pred_taken_q  <= pred_taken_d;
        act_taken_q   <= act_taken_d;
        pc_q          <= pc_d;
        pred_target_q <= pred_target_d;
        act_target_q  <= act_target_d;
    end

    assign rollback_en_o     = rollback_en_q;
    assign rollback_target_o = rollback_target_q;
    assign rollback_tag_o    = rollback_tag_q;
    assign upd_is_branch_o   = upd_is_branch_q;
    assign upd_taken_o       = upd_taken_q;
    assign upd_npc_o         = upd_npc_q;
    assign upd_target_o      = upd_target_q;

endmodule
